// File: rtl/posit_normalizer_pkg.sv
// Shared types and constants for the posit normalise-and-encode stage.
package posit_normalizer_pkg;

    localparam int NBITS_DEF = 8;
    localparam int EN_DEF    = 1;
    localparam int MW        = 8;   // fraction sum width from the mantissa adder
    localparam int SW        = 12;  // signed scale register width

    localparam logic [NBITS_DEF-1:0] MAXPOS = {1'b0, {(NBITS_DEF-1){1'b1}}};
    localparam logic [NBITS_DEF-1:0] MINPOS = {{(NBITS_DEF-1){1'b0}}, 1'b1};

    localparam logic signed [SW-1:0] SCALE_ONE = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ENCODE,
        ST_DONE
    } norm_state_t;

    typedef enum logic {
        SIGN_POS,
        SIGN_NEG
    } sign_t;

    function automatic logic signed [SW-1:0] sext8(input logic [7:0] v);
        return {{(SW-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/posit_normalizer_if.sv
// Operand-in / posit-out handshake bundle between the adder, the normaliser and its consumer.
interface posit_normalizer_if #(
    parameter int NBITS = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       mantissa_sum;
    logic [7:0]       interim_regime;
    logic [7:0]       interim_exponent;
    logic             negate_result;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_posit;

    modport master (
        output in_valid, mantissa_sum, interim_regime, interim_exponent, negate_result, out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, mantissa_sum, interim_regime, interim_exponent, negate_result, out_ready,
        output in_ready, out_valid, out_posit
    );
endinterface

// File: rtl/posit_normalizer_encoder.sv
// Packs regime k, exponent e and fraction into a posit word with saturation and sign.
// POSIT_NORM_ROUND_EN selects round-to-nearest-even of the dropped bits; otherwise truncation.
module posit_encoder
    import posit_normalizer_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int EN    = EN_DEF
) (
    input  logic signed [SW-1:0] k_i,
    input  logic [EN-1:0]        e_i,
    input  logic [MW-2:0]        frac_i,
    input  logic                 zero_i,
    input  sign_t                sign_i,
    output logic [NBITS-1:0]     word_o
);
    localparam int BODY_W = 1 + EN + MW - 1;
    localparam int BUF_W  = NBITS - 1 + BODY_W;
    localparam int RW     = $clog2(BUF_W + 1);
    localparam logic signed [SW-1:0] K_SAT_HI = SW'(NBITS - 2);
    localparam logic signed [SW-1:0] K_SAT_LO = SW'(-(NBITS - 2));

    logic [RW-1:0]    run_len;
    logic [BUF_W-1:0] body_buf;
    logic [BUF_W-1:0] packed_buf;
    logic [NBITS-2:0] trunc;
    logic [NBITS-1:0] rounded;
    logic [NBITS-1:0] mag;
`ifdef POSIT_NORM_ROUND_EN
    logic guard;
    logic sticky;
`else
    logic unused_dropped;
`endif

    always_comb begin
        // Regime run: k>=0 is k+1 ones closed by 0, k<0 is -k zeros closed by 1.
        run_len    = k_i[SW-1] ? RW'(-k_i) : RW'(k_i + SCALE_ONE);
        body_buf   = {k_i[SW-1], e_i, frac_i, {(NBITS-1){1'b0}}} >> run_len;
        packed_buf = k_i[SW-1] ? body_buf : (body_buf | ~({BUF_W{1'b1}} >> run_len));
        trunc      = packed_buf[BUF_W-1 -: NBITS-1];
`ifdef POSIT_NORM_ROUND_EN
        guard      = packed_buf[BODY_W-1];
        sticky     = |packed_buf[BODY_W-2:0];
        rounded    = {1'b0, trunc} + NBITS'(guard & (sticky | trunc[0]));
`else
        unused_dropped = ^packed_buf[BODY_W-1:0];
        rounded    = {1'b0, trunc};
`endif
        if (k_i >= K_SAT_HI)
            mag = MAXPOS;
        else if (k_i < K_SAT_LO)
            mag = MINPOS;
        else if (rounded > MAXPOS)
            mag = MAXPOS;
        else
            mag = rounded;

        if (zero_i)
            word_o = '0;
        else if (sign_i == SIGN_NEG)
            word_o = -mag;
        else
            word_o = mag;
    end

endmodule

// File: rtl/posit_normalizer.sv
// Sequential normalise-and-encode stage behind the posit mantissa adder (one shift per cycle).
// Rounding mode chosen by POSIT_NORM_ROUND_EN in the encoder.
module posit_normalizer
    import posit_normalizer_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int EN    = EN_DEF
) (
    input logic               clk,
    input logic               rst_n,
    posit_normalizer_if.slave bus
);
    norm_state_t          state_q;
    logic [MW-1:0]        m_q;
    logic signed [SW-1:0] s_q;
    sign_t                sign_q;
    logic                 zero_q;
    logic                 out_valid_q;
    logic [NBITS-1:0]     out_posit_q;

    logic signed [SW-1:0] s_d;
    logic signed [SW-1:0] s_adj;
    logic signed [SW-1:0] k_enc;
    logic [EN-1:0]        e_enc;
    logic [NBITS-1:0]     enc_word;

    always_comb begin
        s_d   = (sext8(bus.interim_regime) <<< EN) + sext8(bus.interim_exponent) + SCALE_ONE;
        // m holds 0.f; the packed form is 1.f, one binade lower.
        s_adj = s_q - SCALE_ONE;
        k_enc = s_adj >>> EN;
        e_enc = s_adj[EN-1:0];
    end

    posit_encoder #(
        .NBITS (NBITS),
        .EN    (EN)
    ) u_encoder (
        .k_i    (k_enc),
        .e_i    (e_enc),
        .frac_i (m_q[MW-2:0]),
        .zero_i (zero_q),
        .sign_i (sign_q),
        .word_o (enc_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            s_q         <= '0;
            sign_q      <= SIGN_POS;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        m_q     <= bus.mantissa_sum;
                        s_q     <= s_d;
                        sign_q  <= bus.negate_result ? SIGN_NEG : SIGN_POS;
                        zero_q  <= (bus.mantissa_sum == '0);
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // A zero operand passes through once so every operand sees 2+L latency.
                    if (m_q[MW-1] || zero_q) begin
                        state_q <= ST_ENCODE;
                    end else begin
                        m_q <= m_q << 1;
                        s_q <= s_q - SCALE_ONE;
                    end
                end
                ST_ENCODE: begin
                    out_posit_q <= enc_word;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_posit = out_posit_q;

endmodule

// File: tb/tb_posit_normalizer.sv
// Randomised and directed bench for posit_normalizer against a value-domain posit reference.
module tb_posit_normalizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    posit_normalizer_if #(.NBITS(8)) bus();

    posit_normalizer #(.NBITS(8), .EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    function automatic real pow2(input int p);
        real v;
        v = 1.0;
        if (p >= 0)
            for (int i = 0; i < p; i++) v = v * 2.0;
        else
            for (int i = 0; i < -p; i++) v = v / 2.0;
        return v;
    endfunction

    // Value of a positive, nonzero posit pattern of width n with a 1-bit exponent field.
    function automatic real posit_value(input int pat, input int n);
        int  i;
        int  run;
        int  k;
        int  e;
        bit  lead;
        real f;
        real w;
        i    = n - 2;
        lead = pat[i];
        run  = 0;
        while (i >= 0 && pat[i] == lead) begin
            run++;
            i--;
        end
        k = lead ? run - 1 : -run;
        i--;
        e = 0;
        if (i >= 0) begin
            e = pat[i];
            i--;
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (pat[i] == 1'b1) f = f + w;
            w = w / 2.0;
            i--;
        end
        return pow2(2 * k + e) * f;
    endfunction

    function automatic logic [7:0] ref_posit(input logic [7:0] m, input logic [7:0] r,
                                             input logic [7:0] e, input logic neg);
        real x;
        int  p;
        if (m == 8'h00) return 8'h00;
        x = real'(int'(m)) * pow2(int'($signed(r)) * 2 + int'($signed(e)) + 1 - 8);
        if (x >= posit_value(127, 8)) begin
            p = 127;
        end else if (x < posit_value(1, 8)) begin
            p = 1;
        end else begin
            p = 1;
            for (int c = 2; c <= 126; c++)
                if (posit_value(c, 8) <= x) p = c;
`ifdef POSIT_NORM_ROUND_EN
            begin
                real mid;
                mid = posit_value(2 * p + 1, 9);
                if (x > mid || (x == mid && (p % 2) == 1)) p = p + 1;
            end
`endif
        end
        if (neg) p = -p;
        return 8'(p);
    endfunction

    task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] r,
                          input logic [7:0] e, input logic neg, input logic [7:0] exp_w,
                          input int hold);
        int cyc;
        int exp_lat;
        exp_lat = 2 + ((m == 8'h00) ? 0 : 8 - $clog2(int'(m) + 1));
        @(negedge clk);
        chk({tag, " idle_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid         = 1'b1;
        bus.mantissa_sum     = m;
        bus.interim_regime   = r;
        bus.interim_exponent = e;
        bus.negate_result    = neg;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " posit"}, 32'(bus.out_posit), 32'(exp_w));
        chk({tag, " busy_rdy"}, 32'(bus.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold_posit"}, 32'(bus.out_posit), 32'(exp_w));
            chk({tag, " hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " acc_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " acc_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        logic [7:0] r;
        logic [7:0] e;
        logic       neg;

        bus.in_valid         = 1'b0;
        bus.mantissa_sum     = 8'h00;
        bus.interim_regime   = 8'h00;
        bus.interim_exponent = 8'h00;
        bus.negate_result    = 1'b0;
        bus.out_ready        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_posit", 32'(bus.out_posit), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one", 8'h80, 8'h00, 8'h00, 1'b0, 8'h40, 0);
        run_op("shift1", 8'h40, 8'h00, 8'h01, 1'b0, 8'h40, 1);
        run_op("shift7", 8'h01, 8'h00, 8'h07, 1'b0, 8'h40, 0);
        run_op("neg_one", 8'h80, 8'h00, 8'h00, 1'b1, 8'hC0, 0);
        run_op("neg_zero", 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 0);
        run_op("maxpos", 8'h80, 8'h07, 8'h00, 1'b0, 8'h7F, 0);
        run_op("minpos", 8'h80, 8'hF8, 8'h00, 1'b0, 8'h01, 0);
`ifdef POSIT_NORM_ROUND_EN
        run_op("round_up", 8'h86, 8'h00, 8'h00, 1'b0, 8'h41, 0);
`else
        run_op("trunc", 8'h86, 8'h00, 8'h00, 1'b0, 8'h40, 0);
`endif
        run_op("tie_even", 8'h84, 8'h00, 8'h00, 1'b0, 8'h40, 0);
        run_op("stall5", 8'hC3, 8'h01, 8'hFF, 1'b1,
               ref_posit(8'hC3, 8'h01, 8'hFF, 1'b1), 5);

        // Reset in the middle of a long normalisation, with a handshake offered during reset.
        @(negedge clk);
        bus.in_valid         = 1'b1;
        bus.mantissa_sum     = 8'h01;
        bus.interim_regime   = 8'h02;
        bus.interim_exponent = 8'h00;
        bus.negate_result    = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst in_ready", 32'(bus.in_ready), 32'd1);
        chk("postrst out_valid", 32'(bus.out_valid), 32'd0);
        run_op("after_rst", 8'h01, 8'h00, 8'h07, 1'b0, 8'h40, 0);

        for (int t = 0; t < 200; t++) begin
            m   = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            r   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16)) - 8'd8;
            e   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3)) - 8'd1;
            neg = 1'($urandom);
            run_op($sformatf("rnd%0d", t), m, r, e, neg, ref_posit(m, r, e, neg),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
